// File: rtl/spy_trigger_controller.sv
// Circular spy capture with an SOE/sentinel event list, a trigger countdown and a rearm handshake. Reads take 1 cycle.
// There is no backpressure. Writes are dropped while frozen. Define SPY_EVENT_COUNT_EN to build the event_count counter.
module spy_trigger_controller #(
  parameter int         DATAWIDTH = 64,
  parameter int         MEMWIDTH  = 6,
  parameter int         METAWIDTH = 4,
  parameter logic [7:0] SOE_CODE  = 8'hB0
) (
  input  logic                 clock,
  input  logic                 resetbar,
  input  logic [DATAWIDTH:0]   data_in,
  input  logic                 write_enable_in,
  input  logic                 freeze,
  input  logic                 trigger,
  input  logic [MEMWIDTH-1:0]  post_trig_words,
  input  logic                 rearm,
  input  logic [MEMWIDTH-1:0]  read_addr,
  input  logic                 read_enable_in,
  input  logic [METAWIDTH-1:0] meta_read_addr,
  input  logic                 meta_read_enable,
  output logic [DATAWIDTH:0]   data_out,
  output logic [MEMWIDTH-1:0]  mem_wptr,
  output logic [METAWIDTH-1:0] meta_write_addr,
  output logic [MEMWIDTH:0]    meta_read_data,
  output logic                 frozen,
  output logic [15:0]          event_count
);

  typedef enum logic [2:0] {
    S_RESET,
    S_WRITE,
    S_TRIGGERED,
    S_FROZEN_LVL,
    S_FROZEN
  } state_t;

  typedef struct packed {
    logic                sentinel;
    logic [MEMWIDTH-1:0] addr;
  } evt_t;

  localparam logic [MEMWIDTH-1:0]  WPTR_LAST = '1;
  localparam logic [MEMWIDTH-1:0]  CNT_ONE   = MEMWIDTH'(1);
  localparam logic [METAWIDTH-1:0] META_ONE  = METAWIDTH'(1);

  state_t              state, state_nxt;
  logic [MEMWIDTH-1:0] cnt, cnt_nxt;

  logic [DATAWIDTH:0]  spy_mem  [2**MEMWIDTH];
  evt_t                meta_mem [2**METAWIDTH];

  evt_t                q     [2];
  evt_t                q_nxt [2];
  logic [1:0]          q_cnt, q_cnt_nxt;

  logic                accept, soe, wrap, pop;
  evt_t                soe_ent, sent_ent;

  assign accept = write_enable_in & ((state == S_WRITE) | (state == S_TRIGGERED)) & ~freeze;
  assign soe    = accept & data_in[DATAWIDTH] & (data_in[DATAWIDTH-1 -: 8] == SOE_CODE);
  assign wrap   = accept & (mem_wptr == WPTR_LAST);
  assign pop    = (state != S_RESET) && (q_cnt != 2'd0);
  assign frozen = (state == S_FROZEN) || (state == S_FROZEN_LVL);

  assign soe_ent  = '{sentinel: 1'b0, addr: mem_wptr};
  assign sent_ent = '{sentinel: 1'b1, addr: '0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RESET: state_nxt = S_WRITE;
      S_WRITE: begin
        if (freeze) begin
          state_nxt = S_FROZEN_LVL;
        end else if (trigger) begin
          state_nxt = S_TRIGGERED;
          cnt_nxt   = post_trig_words;
        end
      end
      S_TRIGGERED: begin
        if (accept && (cnt != '0)) cnt_nxt = cnt - CNT_ONE;
        // A completed post-trigger window wins over a level freeze.
        if ((cnt == '0) || (accept && (cnt == CNT_ONE))) state_nxt = S_FROZEN;
        else if (freeze) state_nxt = S_FROZEN_LVL;
      end
      S_FROZEN_LVL: if (!freeze) state_nxt = S_WRITE;
      S_FROZEN: begin
        if (rearm) state_nxt = freeze ? S_FROZEN_LVL : S_WRITE;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Pop first, then append the SOE entry ahead of the sentinel; a full queue drops the extra entry.
  always_comb begin
    q_nxt     = q;
    q_cnt_nxt = q_cnt;
    if (pop) begin
      q_nxt[0]  = q[1];
      q_cnt_nxt = q_cnt - 2'd1;
    end
    if (soe && (q_cnt_nxt != 2'd2)) begin
      q_nxt[q_cnt_nxt[0]] = soe_ent;
      q_cnt_nxt           = q_cnt_nxt + 2'd1;
    end
    if (wrap && (q_cnt_nxt != 2'd2)) begin
      q_nxt[q_cnt_nxt[0]] = sent_ent;
      q_cnt_nxt           = q_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetbar) begin
      state           <= S_RESET;
      cnt             <= '0;
      mem_wptr        <= '0;
      meta_write_addr <= '0;
      q_cnt           <= '0;
      q[0]            <= '0;
      q[1]            <= '0;
      data_out        <= '0;
      meta_read_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q_cnt <= q_cnt_nxt;
      q[0]  <= q_nxt[0];
      q[1]  <= q_nxt[1];
      if (accept) mem_wptr <= mem_wptr + CNT_ONE;
      if (pop) meta_write_addr <= meta_write_addr + META_ONE;
      if (read_enable_in) data_out <= spy_mem[read_addr];
      if (meta_read_enable) meta_read_data <= meta_mem[meta_read_addr];
    end
  end

  // Memories have no reset; a reset edge must not commit a write or a pending pop.
  always_ff @(posedge clock) begin
    if (resetbar && accept) spy_mem[mem_wptr] <= data_in;
    if (resetbar && pop) meta_mem[meta_write_addr] <= q[0];
  end

`ifdef SPY_EVENT_COUNT_EN
  logic [15:0] evt_cnt;

  always_ff @(posedge clock) begin
    if (!resetbar) begin
      evt_cnt <= '0;
    end else if (soe && (evt_cnt != 16'hFFFF)) begin
      evt_cnt <= evt_cnt + 16'd1;
    end
  end

  assign event_count = evt_cnt;
`else
  assign event_count = 16'd0;
`endif

endmodule
